// File: rtl/tdes_round_sequencer.sv
// Triple-DES round sequencer: walks the iterative DES round core through
// PASSES x ROUNDS Feistel rounds per 64-bit chunk and drives the per-round
// key select, direction and subkey index as registered outputs.
// Optional build macro: TDES_SINGLE_MODE_EN (adds single_des, one-pass DES).
module tdes_round_sequencer #(
  parameter int ROUNDS = 16,
  parameter int PASSES = 3
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       keys_valid,
  input  logic       enc_dec,
`ifdef TDES_SINGLE_MODE_EN
  input  logic       single_des,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       load_block,
  output logic       round_en,
  output logic [1:0] key_sel,
  output logic       des_decrypt,
  output logic [3:0] subkey_idx,
  output logic       pass_done,
  output logic       busy
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] PREV_ROUND = RW'(ROUNDS - 2);
  localparam logic [PW-1:0] LAST_PASS  = PW'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  state_t        state;
  logic [RW-1:0] roundCnt;
  logic [PW-1:0] passCnt;
  logic          modeQ;
  logic          singleQ;
  logic [PW-1:0] lastPass;

  // EDE for encrypt (K1 enc, K2 dec, K3 enc), reversed DED for decrypt.
  function automatic logic [1:0] passKey(input logic [PW-1:0] p, input logic mode,
                                         input logic single);
    if (single) return 2'd0;
    return mode ? (2'd2 - 2'(p)) : 2'(p);
  endfunction

  // Middle pass runs opposite to the outer passes; single DES follows the mode.
  function automatic logic passDir(input logic [PW-1:0] p, input logic mode,
                                   input logic single);
    if (single) return mode;
    return mode ^ (p == PW'(1));
  endfunction

  // Decrypt walks the key schedule backwards.
  function automatic logic [3:0] subkeyOf(input logic dir, input logic [RW-1:0] r);
    return dir ? 4'(LAST_ROUND - r) : 4'(r);
  endfunction

  // Ready is a direct view of state so keys_valid gates acceptance the same cycle.
  assign in_ready = (state == IDLE) && keys_valid;
  assign lastPass = singleQ ? '0 : LAST_PASS;

`ifndef TDES_SINGLE_MODE_EN
  assign singleQ = 1'b0;
`endif

  // Control FSM: outputs are loaded with the values for the state being entered.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= IDLE;
      roundCnt    <= '0;
      passCnt     <= '0;
      modeQ       <= 1'b0;
`ifdef TDES_SINGLE_MODE_EN
      singleQ     <= 1'b0;
`endif
      out_valid   <= 1'b0;
      load_block  <= 1'b0;
      round_en    <= 1'b0;
      key_sel     <= 2'd0;
      des_decrypt <= 1'b0;
      subkey_idx  <= 4'd0;
      pass_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            modeQ      <= enc_dec;
`ifdef TDES_SINGLE_MODE_EN
            singleQ    <= single_des;
`endif
            load_block <= 1'b1;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          load_block  <= 1'b0;
          roundCnt    <= '0;
          passCnt     <= '0;
          round_en    <= 1'b1;
          key_sel     <= passKey('0, modeQ, singleQ);
          des_decrypt <= passDir('0, modeQ, singleQ);
          subkey_idx  <= subkeyOf(passDir('0, modeQ, singleQ), '0);
          pass_done   <= 1'b0;
          state       <= ROUND;
        end
        ROUND: begin
          if (roundCnt == LAST_ROUND) begin
            roundCnt  <= '0;
            passCnt   <= passCnt + PW'(1);
            pass_done <= 1'b0;
            if (passCnt == lastPass) begin
              round_en    <= 1'b0;
              key_sel     <= 2'd0;
              des_decrypt <= 1'b0;
              subkey_idx  <= 4'd0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              key_sel     <= passKey(passCnt + PW'(1), modeQ, singleQ);
              des_decrypt <= passDir(passCnt + PW'(1), modeQ, singleQ);
              subkey_idx  <= subkeyOf(passDir(passCnt + PW'(1), modeQ, singleQ), '0);
            end
          end else begin
            roundCnt   <= roundCnt + RW'(1);
            subkey_idx <= subkeyOf(des_decrypt, roundCnt + RW'(1));
            pass_done  <= (roundCnt == PREV_ROUND);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
